// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level single-master I2C engine (START / WRITE / READ / STOP per handshake)
module i2c_byte_master #(
    parameter int DIV = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    input  logic       rd_nack,
    output logic       rsp_valid,
    output logic       rsp_ack,
    output logic [7:0] rsp_data,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);
    localparam logic [15:0] LAST = 16'(DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_DONE} state_t;

    state_t      r_state, w_state;
    logic [1:0]  r_q, w_q;
    logic [15:0] r_cnt, w_cnt;
    logic [3:0]  r_bit, w_bit;
    logic [7:0]  r_tx, w_tx, r_rx, w_rx, r_rsp_data, w_rsp_data;
    logic        r_rd, w_rd, r_nack, w_nack, r_ack, w_ack, r_rsp_ack, w_rsp_ack;
    logic        r_scl, r_sda, w_scl, w_sda, w_dbit;

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_ack   = r_rsp_ack;
    assign rsp_data  = r_rsp_data;
    assign scl_oe    = w_scl;
    assign sda_oe    = w_sda;

    // state, timebase and held bus levels; reset releases both lines without a STOP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_q        <= '0;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rd       <= 1'b0;
            r_nack     <= 1'b0;
            r_ack      <= 1'b0;
            r_rsp_ack  <= 1'b0;
            r_rsp_data <= '0;
            r_scl      <= 1'b0;
            r_sda      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_q        <= w_q;
            r_cnt      <= w_cnt;
            r_bit      <= w_bit;
            r_tx       <= w_tx;
            r_rx       <= w_rx;
            r_rd       <= w_rd;
            r_nack     <= w_nack;
            r_ack      <= w_ack;
            r_rsp_ack  <= w_rsp_ack;
            r_rsp_data <= w_rsp_data;
            r_scl      <= w_scl;
            r_sda      <= w_sda;
        end
    end

    // pad drive per quarter while active; between commands the last levels are held
    always_comb begin
        w_dbit = (r_bit == 4'd0) ? (r_rd & ~r_nack) : (~r_rd & ~r_tx[7]);
        w_scl  = r_scl;
        w_sda  = r_sda;
        case (r_state)
            S_START: begin
                w_scl = (r_q == 2'd0) ? r_scl : (r_q == 2'd3);
                w_sda = r_q[1];
            end
            S_BIT: begin
                w_scl = (r_q == 2'd0) | (r_q == 2'd3);
                w_sda = w_dbit;
            end
            S_STOP: begin
                w_scl = (r_q == 2'd0) & r_scl;
                w_sda = ~r_q[1];
            end
            default: ;
        endcase
    end

    // next state: accept, quarter/bit sequencing, q1 stretch hold, sampling and response capture
    always_comb begin
        w_state    = r_state;
        w_q        = r_q;
        w_cnt      = r_cnt;
        w_bit      = r_bit;
        w_tx       = r_tx;
        w_rx       = r_rx;
        w_rd       = r_rd;
        w_nack     = r_nack;
        w_ack      = r_ack;
        w_rsp_ack  = r_rsp_ack;
        w_rsp_data = r_rsp_data;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state = (cmd == 2'd0) ? S_START : (cmd == 2'd3) ? S_STOP : S_BIT;
                    w_q     = 2'd0;
                    w_cnt   = LAST;
                    w_bit   = 4'd8;
                    w_tx    = wdata;
                    w_rx    = '0;
                    w_rd    = (cmd == 2'd2);
                    w_nack  = rd_nack;
                    w_ack   = 1'b0;
                end
            end
            S_DONE: w_state = S_IDLE;
            default: begin
                if (!((r_q == 2'd1) && !scl_i)) begin
                    if (r_cnt != 16'd0) begin
                        w_cnt = r_cnt - 16'd1;
                    end else begin
                        w_cnt = LAST;
                        if (r_state == S_BIT && r_q == 2'd2) begin
                            w_rx  = (r_bit != 4'd0) ? {r_rx[6:0], sda_i} : r_rx;
                            w_ack = (r_bit == 4'd0) ? ~sda_i : r_ack;
                        end
                        if (r_q != 2'd3) begin
                            w_q = r_q + 2'd1;
                        end else if (r_state == S_BIT && r_bit != 4'd0) begin
                            w_q   = 2'd0;
                            w_bit = r_bit - 4'd1;
                            w_tx  = {r_tx[6:0], 1'b0};
                        end else begin
                            w_state    = S_DONE;
                            w_rsp_ack  = (r_state == S_BIT) & ~r_rd & r_ack;
                            w_rsp_data = (r_state == S_BIT && r_rd) ? r_rx : 8'h00;
                        end
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: randomized bench with a quarter-level bus model checked every cycle
module tb_i2c_byte_master;
    localparam int DIV = 4;

    logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, rd_nack = 1'b0;
    logic [1:0] cmd = '0;
    logic [7:0] wdata = '0;
    logic       cmd_ready, rsp_valid, rsp_ack, scl_oe, sda_oe, scl_i, sda_i;
    logic [7:0] rsp_data;
    logic       stretch = 1'b0, slave_pull = 1'b0;

    assign scl_i = ~(scl_oe | stretch);
    assign sda_i = ~(sda_oe | slave_pull);

    always #5 clk = ~clk;

    i2c_byte_master #(.DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .wdata(wdata), .rd_nack(rd_nack), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .rsp_data(rsp_data), .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    int n_chk = 0, n_pass = 0;
    logic m_en = 1'b0;
    logic e_scl = 1'b0, e_sda = 1'b0, e_ready = 1'b1, e_valid = 1'b0, e_ack = 1'b0;
    logic [7:0] e_data = '0;
    logic m_scl = 1'b0, m_sda = 1'b0;

    typedef struct packed {logic scl; logic sda; logic pull; logic str;} cyc_t;
    cyc_t q[$];
    int g_sq, g_slen, qn;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // every cycle: DUT outputs against the model's expected levels
    always @(negedge clk) begin
        if (m_en) begin
            chk("scl_oe", 32'(scl_oe), 32'(e_scl));
            chk("sda_oe", 32'(sda_oe), 32'(e_sda));
            chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
            chk("rsp_ack", 32'(rsp_ack), 32'(e_ack));
            chk("rsp_data", 32'(rsp_data), 32'(e_data));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic scl, input logic sda, input logic pl);
        if (qn == g_sq) for (int j = 0; j < g_slen; j++) q.push_back(cyc_t'({scl, sda, pl, 1'b1}));
        for (int j = 0; j < DIV; j++) q.push_back(cyc_t'({scl, sda, pl, 1'b0}));
        qn++;
    endtask

    task automatic build(input logic [1:0] c, input logic [7:0] wd, input logic nack,
                         input logic [7:0] sb, input logic sack);
        q.delete();
        qn = 0;
        if (c == 2'd0) begin
            push(m_scl, 1'b0, 1'b0); push(1'b0, 1'b0, 1'b0); push(1'b0, 1'b1, 1'b0); push(1'b1, 1'b1, 1'b0);
        end else if (c == 2'd3) begin
            push(m_scl, 1'b1, 1'b0); push(1'b0, 1'b1, 1'b0); push(1'b0, 1'b0, 1'b0); push(1'b0, 1'b0, 1'b0);
        end else begin
            for (int i = 8; i >= 0; i--) begin
                logic sd, pl;
                sd = (i > 0) ? ((c == 2'd1) ? ~wd[i-1] : 1'b0) : ((c == 2'd2) ? ~nack : 1'b0);
                pl = (i > 0) ? ((c == 2'd2) ? ~sb[i-1] : 1'b0) : ((c == 2'd1) ? sack : 1'b0);
                push(1'b1, sd, pl); push(1'b0, sd, pl); push(1'b0, sd, pl); push(1'b1, sd, pl);
            end
        end
    endtask

    task automatic run(input logic [1:0] c, input logic [7:0] wd, input logic nack, input logic [7:0] sb,
                       input logic sack, input int sq, input int slen, input int abort_at,
                       output int lat, output logic [8:0] seen);
        g_sq = sq;
        g_slen = slen;
        build(c, wd, nack, sb, sack);
        lat = -1;
        seen = '0;
        cmd_valid = 1'b1; cmd = c; wdata = wd; rd_nack = nack;
        for (int k = 0; k < q.size(); k++) begin
            step();
            e_scl = q[k].scl; e_sda = q[k].sda; e_ready = 1'b0; e_valid = 1'b0;
            slave_pull = q[k].pull; stretch = q[k].str;
            cmd_valid = 1'($urandom_range(0, 1)); cmd = 2'($urandom); wdata = 8'($urandom); rd_nack = 1'($urandom);
            if (rsp_valid && lat < 0) lat = k + 1;
            if ((c == 2'd1 || c == 2'd2) && slen == 0 && k % (4 * DIV) == 2 * DIV) seen = {seen[7:0], sda_oe};
            if (k == abort_at) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1; cmd_valid = 1'b0; stretch = 1'b0; slave_pull = 1'b0;
                e_scl = 1'b0; e_sda = 1'b0; e_ready = 1'b1; e_valid = 1'b0; e_ack = 1'b0; e_data = '0;
                m_scl = 1'b0; m_sda = 1'b0;
                return;
            end
        end
        step();
        if (rsp_valid && lat < 0) lat = q.size() + 1;
        e_valid = 1'b1; stretch = 1'b0; slave_pull = 1'b0;
        cmd_valid = 1'($urandom_range(0, 1)); cmd = 2'($urandom);
        e_ack = (c == 2'd1) & sack;
        e_data = (c == 2'd2) ? sb : 8'h00;
        m_scl = e_scl; m_sda = e_sda;
        step();
        e_valid = 1'b0; e_ready = 1'b1; cmd_valid = 1'b0;
    endtask

    initial begin
        int lat;
        logic [8:0] seen;
        step();
        m_en = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        run(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, -1, lat, seen);
        chk("lat_start", 32'(lat), 32'd17);
        run(2'd1, 8'h54, 1'b0, 8'h00, 1'b1, -1, 0, -1, lat, seen);
        chk("lat_write", 32'(lat), 32'd145);
        chk("bits_54", 32'(seen), 32'h156);
        chk("ack_54", 32'(rsp_ack), 32'd1);
        run(2'd1, 8'hC3, 1'b0, 8'h00, 1'b0, -1, 0, -1, lat, seen);
        chk("nack_ack", 32'(rsp_ack), 32'd0);
        chk("nack_data", 32'(rsp_data), 32'd0);
        run(2'd2, 8'h00, 1'b1, 8'hA5, 1'b0, -1, 0, -1, lat, seen);
        chk("rd_data", 32'(rsp_data), 32'hA5);
        chk("rd_nack_bit", 32'(seen[0]), 32'd0);
        run(2'd2, 8'h00, 1'b0, 8'h3C, 1'b0, -1, 0, -1, lat, seen);
        chk("rd_ack_bit", 32'(seen[0]), 32'd1);
        run(2'd1, 8'h9E, 1'b0, 8'h00, 1'b1, 13, 20, -1, lat, seen);
        chk("lat_stretch", 32'(lat), 32'd165);
        run(2'd3, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, -1, lat, seen);
        chk("lat_stop", 32'(lat), 32'd17);
        for (int n = 0; n < 40; n++) begin
            logic [1:0] c;
            int nb, sl;
            c = 2'($urandom);
            nb = (c == 2'd1 || c == 2'd2) ? 9 : 1;
            sl = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
            run(c, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                4 * $urandom_range(0, nb - 1) + 1, sl, -1, lat, seen);
        end
        run(2'd1, 8'h5A, 1'b0, 8'h00, 1'b1, -1, 0, $urandom_range(10, 120), lat, seen);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        run(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, -1, lat, seen);
        run(2'd2, 8'h00, 1'b1, 8'h81, 1'b0, -1, 0, -1, lat, seen);
        chk("post_abort_rd", 32'(rsp_data), 32'h81);
        run(2'd3, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, -1, lat, seen);
        step();
        m_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
